// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, multiplier FSM
// states and the default datapath width.
package ex_pkg;

    localparam int DATA_W_DEF = 32;

    // MIPS funct-field values, so the decoder can pass funct straight through
    typedef enum logic [5:0] {
        OP_SLL  = 6'h00,
        OP_SRL  = 6'h02,
        OP_MFHI = 6'h10,
        OP_MFLO = 6'h12,
        OP_MULT = 6'h18,
        OP_ADD  = 6'h20,
        OP_SUB  = 6'h22,
        OP_AND  = 6'h24,
        OP_OR   = 6'h25,
        OP_XOR  = 6'h26,
        OP_NOR  = 6'h27,
        OP_SLT  = 6'h2A
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The pipeline side drives the master
// modport; the execute stage sits on the slave modport.
interface ex_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic [DATA_W-1:0] reg_data1;
    logic [DATA_W-1:0] reg_data2;
    logic [DATA_W-1:0] sign_ext_offset;
    logic [4:0]        rd;
    logic [4:0]        rt;
    logic              ALUsrc;
    logic [5:0]        ALUop;
    logic              RegDst;
    logic              memRead;
    logic              memWrite;
    logic              MemtoReg;
    logic              RegWrite;

    logic              stall;
    logic [DATA_W-1:0] alu_result_out;
    logic              zero_out;
    logic [DATA_W-1:0] write_data_out;
    logic [4:0]        write_reg_out;
    logic              memRead_out;
    logic              memWrite_out;
    logic              MemtoReg_out;
    logic              RegWrite_out;

    modport master (
        output flush, reg_data1, reg_data2, sign_ext_offset, rd, rt, ALUsrc, ALUop,
               RegDst, memRead, memWrite, MemtoReg, RegWrite,
        input  stall, alu_result_out, zero_out, write_data_out, write_reg_out,
               memRead_out, memWrite_out, MemtoReg_out, RegWrite_out
    );

    modport slave (
        input  flush, reg_data1, reg_data2, sign_ext_offset, rd, rt, ALUsrc, ALUop,
               RegDst, memRead, memWrite, MemtoReg, RegWrite,
        output stall, alu_result_out, zero_out, write_data_out, write_reg_out,
               memRead_out, memWrite_out, MemtoReg_out, RegWrite_out
    );
endinterface

// File: rtl/mult_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   BUSY  | shift-add step each cycle; done pulses on the last step
//   DONE  | one release cycle, then back to IDLE
module mult_seq
    import ex_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MUL_ITER = DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     a_mag,
    input  logic [DATA_W-1:0]     b_mag,
    output mul_state_e            state,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITER - 1);

    mul_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] step_sum;

    // Product is taken from the adder output so the final step lands on the done edge
    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = step_sum;
    assign state    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q == BUSY);
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    done    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (state_q == IDLE && start) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a_mag};
            mplier_q <= b_mag;
        end else if (state_q == BUSY) begin
            if (abort || cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (!abort) begin
                acc_q    <= step_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU mux, HI/LO with sequential signed MULT, stall generation
// and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MUL_ITER = DATA_W
) (
    input logic clk,
    input logic reset,
    ex_if.slave ex
);
    logic [DATA_W-1:0]   op_a, op_b, alu_res, a_mag, b_mag;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [4:0]          shamt, dest;
    logic                op_mult, bubble, mul_start, mul_busy, mul_done, sign_q;
    logic [2*DATA_W-1:0] mul_prod, mul_signed;
    mul_state_e          mul_state;

    logic [DATA_W-1:0]   res_q, wdata_q;
    logic [4:0]          wreg_q;
    logic                zero_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;

    assign op_a    = ex.reg_data1;
    assign op_b    = ex.ALUsrc ? ex.sign_ext_offset : ex.reg_data2;
    assign shamt   = ex.sign_ext_offset[10:6];
    assign dest    = ex.RegDst ? ex.rd : ex.rt;
    assign op_mult = (ex.ALUop == OP_MULT);
    assign a_mag   = op_a[DATA_W-1] ? -op_a : op_a;
    assign b_mag   = op_b[DATA_W-1] ? -op_b : op_b;

    // A flush kills the MULT in EX, so it must not start or keep the pipe held
    assign mul_start = op_mult && !ex.flush;
    assign ex.stall  = op_mult && !ex.flush && (mul_busy || mul_state == IDLE);
    assign bubble    = ex.flush || op_mult;

    mult_seq #(
        .DATA_W   (DATA_W),
        .MUL_ITER (MUL_ITER)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (ex.flush),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .state   (mul_state),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign mul_signed = sign_q ? -mul_prod : mul_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (mul_start && mul_state == IDLE) begin
                sign_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            end
            if (mul_done) begin
                {hi_q, lo_q} <= mul_signed;
            end
        end
    end

    always_comb begin
        alu_res = '0;
        case (ex.ALUop)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Bubbles clear the controls only; data fields keep their last value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q        <= '0;
            zero_q       <= 1'b0;
            wdata_q      <= '0;
            wreg_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else if (bubble) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            res_q        <= alu_res;
            zero_q       <= (alu_res == '0);
            wdata_q      <= ex.reg_data2;
            wreg_q       <= dest;
            mem_read_q   <= ex.memRead;
            mem_write_q  <= ex.memWrite;
            mem_to_reg_q <= ex.MemtoReg;
            reg_write_q  <= ex.RegWrite;
        end
    end

    assign ex.alu_result_out = res_q;
    assign ex.zero_out       = zero_q;
    assign ex.write_data_out = wdata_q;
    assign ex.write_reg_out  = wreg_q;
    assign ex.memRead_out    = mem_read_q;
    assign ex.memWrite_out   = mem_write_q;
    assign ex.MemtoReg_out   = mem_to_reg_q;
    assign ex.RegWrite_out   = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed vectors for ex_stage: ALU ops, sequential MULT with stall/bubbles,
// flush abort and reset mid-MULT.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    ex_if #(.DATA_W(32)) bus ();

    ex_stage #(.DATA_W(32), .MUL_ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] ctl_o;
    assign ctl_o = {bus.memRead_out, bus.memWrite_out, bus.MemtoReg_out, bus.RegWrite_out};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ctl = {memRead, memWrite, MemtoReg, RegWrite}
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic dst,
                         input logic [4:0] rd_i, input logic [4:0] rt_i, input logic [3:0] ctl);
        bus.ALUop           = op;
        bus.reg_data1       = a;
        bus.reg_data2       = b;
        bus.sign_ext_offset = imm;
        bus.ALUsrc          = src;
        bus.RegDst          = dst;
        bus.rd              = rd_i;
        bus.rt              = rt_i;
        {bus.memRead, bus.memWrite, bus.MemtoReg, bus.RegWrite} = ctl;
    endtask

    // MULT already presented: count stall cycles, then step through the DONE cycle
    task automatic run_mult(input string tag, input logic [31:0] held_res);
        int n;
        n = 0;
        #1;
        while (bus.stall && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, n, 33);
        check({tag, "_bubble_ctl"}, ctl_o, 4'h0);
        check({tag, "_data_hold"}, bus.alu_result_out, held_res);
        tick();
        check({tag, "_done_ctl"}, ctl_o, 4'h0);
        check({tag, "_done_hold"}, bus.alu_result_out, held_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        bus.flush = 1'b0;
        drive(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        #12;
        check("rst_res", bus.alu_result_out, 0);
        check("rst_zero", bus.zero_out, 0);
        check("rst_wdata", bus.write_data_out, 0);
        check("rst_wreg", bus.write_reg_out, 0);
        check("rst_ctl", ctl_o, 0);
        check("rst_stall", bus.stall, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        drive(OP_ADD, 5, 7, 0, 0, 1, 9, 3, 4'b0001); tick();
        check("add_res", bus.alu_result_out, 12);
        check("add_wreg", bus.write_reg_out, 9);
        check("add_ctl", ctl_o, 4'b0001);
        check("add_zero", bus.zero_out, 0);
        check("add_wdata", bus.write_data_out, 7);

        drive(OP_SUB, 32'h10, 32'h55, 32'h10, 1, 0, 9, 4, 4'b1010); tick();
        check("sub_res", bus.alu_result_out, 0);
        check("sub_zero", bus.zero_out, 1);
        check("sub_wreg", bus.write_reg_out, 4);
        check("sub_ctl", ctl_o, 4'b1010);
        check("sub_wdata", bus.write_data_out, 32'h55);

        drive(OP_SLT, 32'hFFFF_FFFF, 1, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("slt_neg", bus.alu_result_out, 1);
        drive(OP_SLT, 1, 32'hFFFF_FFFF, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("slt_pos", bus.alu_result_out, 0);
        drive(OP_SLL, 0, 3, 32'h100, 0, 1, 2, 3, 4'b0001); tick();
        check("sll", bus.alu_result_out, 32'h30);
        drive(OP_SRL, 0, 32'h80, 32'h100, 0, 1, 2, 3, 4'b0001); tick();
        check("srl", bus.alu_result_out, 8);
        drive(OP_NOR, 32'hF0F0_0000, 32'h0F0F_0000, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("nor", bus.alu_result_out, 32'h0000_FFFF);
        drive(OP_XOR, 32'hFF00, 32'h0FF0, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("xor", bus.alu_result_out, 32'hF0F0);
        drive(OP_AND, 32'hFF00, 32'h0FF0, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("and", bus.alu_result_out, 32'h0F00);
        drive(OP_OR, 32'hFF00, 32'h0FF0, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("or", bus.alu_result_out, 32'hFFF0);
        drive(6'h3F, 5, 7, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("unk_res", bus.alu_result_out, 0);
        check("unk_ctl", ctl_o, 4'b0001);

        drive(OP_ADD, 32'h21, 0, 0, 0, 1, 2, 3, 4'b0001); tick();
        check("pre_mult", bus.alu_result_out, 32'h21);
        drive(OP_MULT, 32'hFFFF_FFF9, 3, 0, 0, 1, 5, 6, 4'b1101);
        run_mult("m1", 32'h21);
        drive(OP_MFHI, 0, 0, 0, 0, 1, 8, 0, 4'b0001); tick();
        check("m1_hi", bus.alu_result_out, 32'hFFFF_FFFF);
        check("m1_hi_ctl", ctl_o, 4'b0001);
        drive(OP_MFLO, 0, 0, 0, 0, 1, 8, 0, 4'b0001); tick();
        check("m1_lo", bus.alu_result_out, 32'hFFFF_FFEB);

        drive(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 5, 6, 4'b0001);
        run_mult("m2", 32'hFFFF_FFEB);
        run_mult("m3", 32'hFFFF_FFEB);
        drive(OP_MFHI, 0, 0, 0, 0, 1, 8, 0, 4'b0001); tick();
        check("m2_hi", bus.alu_result_out, 32'h4000_0000);
        drive(OP_MFLO, 0, 0, 0, 0, 1, 8, 0, 4'b0001); tick();
        check("m2_lo", bus.alu_result_out, 0);

        drive(OP_MULT, 6, 7, 0, 0, 1, 5, 6, 4'b0001);
        #1;
        check("fl_start_stall", bus.stall, 1);
        repeat (10) tick();
        check("fl_busy_stall", bus.stall, 1);
        bus.flush = 1'b1;
        #1;
        check("fl_stall_drop", bus.stall, 0);
        tick();
        check("fl_ctl", ctl_o, 0);
        bus.flush = 1'b0;
        drive(OP_MFLO, 0, 0, 0, 0, 1, 8, 0, 4'b0001);
        #1;
        check("fl_after_stall", bus.stall, 0);
        tick();
        check("fl_lo_prior", bus.alu_result_out, 0);
        drive(OP_MFHI, 0, 0, 0, 0, 1, 8, 0, 4'b0001); tick();
        check("fl_hi_prior", bus.alu_result_out, 32'h4000_0000);

        drive(OP_ADD, 32'h1000, 32'h234, 0, 0, 1, 7, 3, 4'b0001); tick();
        check("pre_rst_res", bus.alu_result_out, 32'h1234);
        drive(OP_MULT, 5, 5, 0, 0, 1, 5, 6, 4'b0001);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("mrst_res", bus.alu_result_out, 0);
        check("mrst_wreg", bus.write_reg_out, 0);
        check("mrst_wdata", bus.write_data_out, 0);
        check("mrst_ctl", ctl_o, 0);
        drive(OP_MFHI, 0, 0, 0, 0, 1, 8, 0, 4'b0000);
        #1;
        check("mrst_stall", bus.stall, 0);
        reset = 1'b0;
        tick();
        check("mrst_hi", bus.alu_result_out, 0);
        check("mrst_hi_stall", bus.stall, 0);
        drive(OP_ADD, 1, 1, 0, 0, 1, 4, 3, 4'b0001); tick();
        check("mrst_add", bus.alu_result_out, 2);
        check("mrst_add_ctl", ctl_o, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
